// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter.
// Bytes enter a small FIFO through a valid/ready handshake and are shifted out LSB first.
// Frames are sent back to back with no idle gap while bytes remain queued.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7,
// which gives 8E1 framing (11 bits per frame).
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       i_Clk,
  input  logic       i_rst_n,
  input  logic       i_tx_dv,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_tx_serial,
  output logic       o_tx_active,
  output logic       o_tx_done
);

  localparam int unsigned CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CountW = PtrW + 1;

  localparam logic [CntW-1:0]   CntMax   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CountW-1:0] FifoFull = CountW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic [7:0]        fifo_head;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  // Transmit FSM state
  state_e          state_q;
  logic [CntW-1:0] clk_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shreg_q;
  logic            serial_q;
  logic            active_q;
  logic            done_q;
  logic            bit_end;

  assign o_tx_ready  = (count_q < FifoFull);
  assign o_tx_serial = serial_q;
  assign o_tx_active = active_q;
  assign o_tx_done   = done_q;

  assign fifo_head  = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign push       = i_tx_dv && o_tx_ready;
  assign bit_end    = (clk_cnt_q == CntMax);

  // Pop whenever the FSM is ready to start a frame: from idle, or on the last stop-bit cycle
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state_q == StIdle) begin
        pop = 1'b1;
      end else if ((state_q == StStop) && bit_end) begin
        pop = 1'b1;
      end
    end
  end

  // FIFO data array; contents need no reset since pointers gate every read
  always_ff @(posedge i_Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_tx_byte;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of 2
  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Frame sequencer with registered line, active and done outputs
  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (pop) begin
            shreg_q  <= fifo_head;
            serial_q <= 1'b0;
            active_q <= 1'b1;
            state_q  <= StStart;
          end else begin
            serial_q <= 1'b1;
            active_q <= 1'b0;
          end
        end

        StStart: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            serial_q  <= shreg_q[0];
            state_q   <= StData;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        StData: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
              // Even parity: the parity bit makes the count of ones in data+parity even
              serial_q  <= ^shreg_q;
              state_q   <= StParity;
`else
              serial_q  <= 1'b1;
              state_q   <= StStop;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              serial_q  <= shreg_q[bit_idx_q + 3'd1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            serial_q  <= 1'b1;
            state_q   <= StStop;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
`endif

        StStop: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            done_q    <= 1'b1;
            if (pop) begin
              // Chain straight into the next start bit so frames have no idle gap
              shreg_q  <= fifo_head;
              serial_q <= 1'b0;
              state_q  <= StStart;
            end else begin
              serial_q <= 1'b1;
              active_q <= 1'b0;
              state_q  <= StIdle;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        default: begin
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          serial_q  <= 1'b1;
          active_q  <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule
